// File: rtl/v_pipe_query_pkg.sv
// Shared types and sizing for the table query pipe.
package v_pipe_query_pkg;

    localparam int ENTRIES_N   = 8;
    localparam int KEY_BITS    = 32;
    localparam int VOLUME_BITS = 32;
    localparam int IDX_W       = $clog2(ENTRIES_N);
    localparam int CNT_W       = IDX_W + 1;

    typedef logic [KEY_BITS-1:0]    key_t;
    typedef logic [VOLUME_BITS-1:0] volume_t;
    typedef logic [IDX_W-1:0]       idx_t;
    typedef logic [CNT_W-1:0]       cnt_t;

    // Encoding 2'd3 is reserved and answered with a single miss.
    typedef enum logic [1:0] {
        QRY_TOP = 2'd0,
        QRY_KEY = 2'd1,
        QRY_ALL = 2'd2
    } query_op_t;

    typedef struct packed {
        logic    hit;
        idx_t    idx;
        key_t    key;
        volume_t volume;
        logic    last;
    } query_rsp_t;

endpackage

// File: rtl/v_pipe_query_if.sv
// Command, current-state and response bundle of the query pipe.
interface v_pipe_query_if;
    import v_pipe_query_pkg::*;

    logic                   i_cmd_vld;
    query_op_t              i_cmd_op;
    key_t                   i_cmd_key;
    logic                   o_cmd_rdy;
    logic [ENTRIES_N-1:0]   i_stcur_vld_r;
    key_t [ENTRIES_N-1:0]   i_stcur_keys_r;
    volume_t [ENTRIES_N-1:0] i_stcur_volumes_r;
    logic                   o_rsp_vld;
    logic                   i_rsp_rdy;
    logic                   o_rsp_hit;
    idx_t                   o_rsp_idx;
    key_t                   o_rsp_key;
    volume_t                o_rsp_volume;
    logic                   o_rsp_last;

    modport master (
        output i_cmd_vld, i_cmd_op, i_cmd_key,
        output i_stcur_vld_r, i_stcur_keys_r, i_stcur_volumes_r,
        output i_rsp_rdy,
        input  o_cmd_rdy, o_rsp_vld, o_rsp_hit, o_rsp_idx,
        input  o_rsp_key, o_rsp_volume, o_rsp_last
    );

    modport slave (
        input  i_cmd_vld, i_cmd_op, i_cmd_key,
        input  i_stcur_vld_r, i_stcur_keys_r, i_stcur_volumes_r,
        input  i_rsp_rdy,
        output o_cmd_rdy, o_rsp_vld, o_rsp_hit, o_rsp_idx,
        output o_rsp_key, o_rsp_volume, o_rsp_last
    );

endinterface

// File: rtl/v_pipe_query_cmp.sv
// Key equality primitive shared with the update side.
module v_pipe_query_cmp #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_eq
);

    assign o_eq = (i_a == i_b);

endmodule

// File: rtl/v_pipe_query_sel.sv
// Combinational response builder: given a table view, op, key and the index
// to present, produces the response fields and whether it ends the command.
module v_pipe_query_sel
    import v_pipe_query_pkg::*;
(
    input  logic [ENTRIES_N-1:0]    vld,
    input  key_t [ENTRIES_N-1:0]    keys,
    input  volume_t [ENTRIES_N-1:0] volumes,
    input  query_op_t               op,
    input  key_t                    key,
    input  idx_t                    idx,
    output query_rsp_t              rsp,
    output logic                    multi_hit
);

    logic [ENTRIES_N-1:0] key_eq;
    logic [ENTRIES_N-1:0] match_sel;
    cnt_t                 n_vld;
    idx_t                 match_idx;
    volume_t              match_vol;

    for (genvar i = 0; i < ENTRIES_N; i++) begin : g_cmp
        v_pipe_query_cmp #(.W(KEY_BITS)) u_cmp (
            .i_a  (keys[i]),
            .i_b  (key),
            .o_eq (key_eq[i])
        );
    end

    assign match_sel = vld & key_eq;
    assign multi_hit = |(match_sel & (match_sel - ENTRIES_N'(1)));

    // Entry count and one-hot match decode (match is at most one-hot, so OR works).
    always_comb begin
        n_vld     = '0;
        match_idx = '0;
        match_vol = '0;
        for (int i = 0; i < ENTRIES_N; i++) begin
            n_vld = n_vld + cnt_t'(vld[i]);
            if (match_sel[i]) begin
                match_idx = match_idx | idx_t'(i);
                match_vol = match_vol | volumes[i];
            end
        end
    end

    // Response fields per op; every op except a non-final QRY_ALL index ends the command.
    always_comb begin
        rsp      = '0;
        rsp.last = 1'b1;
        case (op)
            QRY_TOP: begin
                rsp.hit = vld[0];
                if (vld[0]) begin
                    rsp.key    = keys[0];
                    rsp.volume = volumes[0];
                end
            end
            QRY_KEY: begin
                rsp.hit    = |match_sel;
                rsp.idx    = match_idx;
                rsp.key    = key;
                rsp.volume = match_vol;
            end
            QRY_ALL: begin
                if (n_vld != '0) begin
                    rsp.hit    = 1'b1;
                    rsp.idx    = idx;
                    rsp.key    = keys[idx];
                    rsp.volume = volumes[idx];
                    rsp.last   = (cnt_t'(idx) == n_vld - cnt_t'(1));
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/v_pipe_query.sv
// Read-side query pipe: snapshots the current table on command accept and
// streams registered responses in index order over valid/ready.
module v_pipe_query
    import v_pipe_query_pkg::*;
(
    input  logic           clk,
    input  logic           arst_n,
    v_pipe_query_if.slave  bus
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                  state;
    logic [ENTRIES_N-1:0]    snap_vld;
    key_t [ENTRIES_N-1:0]    snap_keys;
    volume_t [ENTRIES_N-1:0] snap_volumes;
    query_op_t               op_q;
    key_t                    key_q;
    query_rsp_t              rsp_q;
    logic                    rsp_vld;

    logic                    idle;
    logic                    accept;
    logic [ENTRIES_N-1:0]    sel_vld;
    key_t [ENTRIES_N-1:0]    sel_keys;
    volume_t [ENTRIES_N-1:0] sel_volumes;
    query_op_t               sel_op;
    key_t                    sel_key;
    idx_t                    sel_idx;
    query_rsp_t              sel_rsp;
    logic                    multi_hit;

    assign idle   = (state == IDLE);
    assign accept = bus.i_cmd_vld & idle;

    // While idle the builder looks at the live bus so the first response can be
    // loaded on the accept edge; afterwards it only sees the snapshot.
    assign sel_vld     = idle ? bus.i_stcur_vld_r     : snap_vld;
    assign sel_keys    = idle ? bus.i_stcur_keys_r    : snap_keys;
    assign sel_volumes = idle ? bus.i_stcur_volumes_r : snap_volumes;
    assign sel_op      = idle ? bus.i_cmd_op          : op_q;
    assign sel_key     = idle ? bus.i_cmd_key         : key_q;
    assign sel_idx     = idle ? '0 : rsp_q.idx + idx_t'(1);

    v_pipe_query_sel u_sel (
        .vld       (sel_vld),
        .keys      (sel_keys),
        .volumes   (sel_volumes),
        .op        (sel_op),
        .key       (sel_key),
        .idx       (sel_idx),
        .rsp       (sel_rsp),
        .multi_hit (multi_hit)
    );

    // Control FSM with snapshot and registered response outputs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state        <= IDLE;
            snap_vld     <= '0;
            snap_keys    <= '0;
            snap_volumes <= '0;
            op_q         <= QRY_TOP;
            key_q        <= '0;
            rsp_q        <= '0;
            rsp_vld      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        snap_vld     <= bus.i_stcur_vld_r;
                        snap_keys    <= bus.i_stcur_keys_r;
                        snap_volumes <= bus.i_stcur_volumes_r;
                        op_q         <= bus.i_cmd_op;
                        key_q        <= bus.i_cmd_key;
                        rsp_q        <= sel_rsp;
                        rsp_vld      <= 1'b1;
                        state        <= EMIT;
                    end
                end
                EMIT: begin
                    if (rsp_vld && bus.i_rsp_rdy) begin
                        if (rsp_q.last) begin
                            rsp_vld <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            rsp_q <= sel_rsp;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_cmd_rdy    = idle;
    assign bus.o_rsp_vld    = rsp_vld;
    assign bus.o_rsp_hit    = rsp_q.hit;
    assign bus.o_rsp_idx    = rsp_q.idx;
    assign bus.o_rsp_key    = rsp_q.key;
    assign bus.o_rsp_volume = rsp_q.volume;
    assign bus.o_rsp_last   = rsp_q.last;

    a_reserved_op: assert property (@(posedge clk) disable iff (!arst_n)
        accept |-> (bus.i_cmd_op != query_op_t'(2'd3)))
        else $error("reserved query op accepted");

    a_key_onehot: assert property (@(posedge clk) disable iff (!arst_n)
        (accept && bus.i_cmd_op == QRY_KEY) |-> !multi_hit)
        else $error("QRY_KEY matched more than one entry");

endmodule

// File: doc/v_pipe_query.md
Name: v_pipe_query

Overview:
- Read-side counterpart of the table update pipe. The update side compares a command key against the sorted table to decide where to write; this block answers read commands against the same table.
- Accepts one query command and snapshots the current state (valid, keys, volumes).
- Streams responses in sorted order (index 0 = best price) over a valid/ready interface.
- Sits beside the update pipe on the same current-state bus; the update pipe never needs to stall.

Parameters:
- ENTRIES_N, cfg_pkg::ENTRIES_N (8), table depth; valid entries are contiguous from index 0.
- KEY_BITS, v_pkg::KEY_BITS (32), key width.
- VOLUME_BITS, v_pkg::VOLUME_BITS (32), volume width.
- IDX_W, $clog2(ENTRIES_N), entry index width.

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- i_cmd_vld  in  1  query command valid
- i_cmd_op  in  v_pkg::query_op_t (2)  QRY_TOP=0, QRY_KEY=1, QRY_ALL=2; 3 reserved
- i_cmd_key  in  KEY_BITS  lookup key; used by QRY_KEY only
- o_cmd_rdy  out  1  command accept
- i_stcur_vld_r  in  ENTRIES_N  current-state valid vector
- i_stcur_keys_r  in  ENTRIES_N x KEY_BITS  current-state keys
- i_stcur_volumes_r  in  ENTRIES_N x VOLUME_BITS  current-state volumes
- o_rsp_vld  out  1  response valid
- i_rsp_rdy  in  1  response accept
- o_rsp_hit  out  1  response carries a real entry
- o_rsp_idx  out  IDX_W  table index of the response
- o_rsp_key  out  KEY_BITS  entry key
- o_rsp_volume  out  VOLUME_BITS  entry volume
- o_rsp_last  out  1  final response of the command

Behaviour:
- Clock and reset: single clock clk; reset arst_n is asynchronous, active-low.
- State machine: IDLE and EMIT. o_cmd_rdy = (state == IDLE), decoded from the state register only.
- Values at reset: state IDLE, o_cmd_rdy 1, o_rsp_vld 0, all response fields 0, snapshot registers 0.
- Command accept: i_cmd_vld & o_cmd_rdy. Same edge:
  - snapshot vld, keys and volumes;
  - latch op and key;
  - load the first response into the output registers;
  - go to EMIT.
- Latency: o_rsp_vld rises exactly 1 cycle after accept. All outputs are registered.
- QRY_TOP:
  - one response, last=1;
  - hit = vld[0]; idx 0; key/volume = entry 0 if hit, else 0.
- QRY_KEY:
  - one response, last=1;
  - match_sel[i] = vld[i] & (keys[i] == cmd_key); hit = |match_sel;
  - idx = one-hot-to-binary of match_sel;
  - key = cmd_key always; volume = matched volume, else 0.
  - More than one set bit in match_sel is illegal; flag with an assertion.
- QRY_ALL:
  - n = popcount(vld). Emit indices 0..n-1 in order, hit=1, last=1 on index n-1.
  - n == 0: one response with hit=0, idx 0, key 0, volume 0, last=1.
  - n == ENTRIES_N: index ENTRIES_N-1 carries last=1; the counter must not wrap past it.
- Reserved op: one response with hit=0 and last=1. An assertion fires.
- Handshake rules:
  - A response transfers on o_rsp_vld & i_rsp_rdy.
  - While o_rsp_vld & !i_rsp_rdy, all o_rsp_* hold stable.
  - o_rsp_vld never drops without a transfer.
  - On a transfer with last=0: load the next index the next cycle, with o_rsp_vld held high, giving 1 response/cycle under full ready.
  - On a transfer with last=1: o_rsp_vld goes 0 and the state returns to IDLE. A new command is acceptable the following cycle, so the minimum command period is n+1 cycles.
- Snapshot isolation: changes on i_stcur_* after accept do not affect in-flight responses.
- Reset mid-operation: arst_n low forces IDLE and o_rsp_vld 0 immediately; the partial stream is discarded.

Decomposition:
- v_pkg additions:
  - query_op_t enum (QRY_TOP, QRY_KEY, QRY_ALL);
  - VOLUME_BITS and volume_t, if not already present;
  - query_rsp_t struct (hit, idx, key, volume, last).
- cfg_pkg: ENTRIES_N and the derived IDX_W.
- One sub-module, v_pipe_query_sel (combinational). It takes the snapshot, op, key and current index, and produces the next response fields and last. Key equality reuses the existing cmp primitive (o_eq).

Test Plan (ENTRIES_N=8):
- Reset, then QRY_ALL with vld=8'b0000_0111, keys {30,20,10} at idx {2,1,0}, rdy=1 -> responses for idx 0,1,2 with keys 10,20,30 on consecutive cycles, first 1 cycle after accept, last=1 on idx 2; o_cmd_rdy returns 1 the next cycle.
- QRY_KEY key=20 on the same table -> single response hit=1, idx=1, volume of entry 1, last=1. Key=25 -> hit=0, volume=0, key=25.
- QRY_ALL with vld=0 -> one response hit=0, last=1. QRY_TOP with vld=0 -> hit=0.
- QRY_ALL with vld=8'hFF and i_rsp_rdy toggling 1,0,0,1,... -> outputs stable while rdy=0; exactly 8 transfers, idx 0..7, last only on idx 7.
- Accept QRY_ALL, then rewrite all i_stcur_keys_r to 0 the next cycle -> streamed keys equal the snapshot values.
- Assert arst_n low during the 2nd response of a 5-entry QRY_ALL -> o_rsp_vld 0 asynchronously, o_cmd_rdy 1 after release, next command served normally.
